im_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the 1K-word instruction memory (IM: word address addr[11:2], combinational 32-bit instr).
- Owns the PC, drives the IM address and registers each fetched word into a valid/ready IF output slot toward decode.
- Handles stall, redirect (branch/jump flush) and an address-window fault that stops fetching until reset.

---
 rtl/im_fetch_ctrl_if.sv | 22 ++
 rtl/im_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_im_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/im_fetch_ctrl_if.sv
// Decode-side handshake of the fetch stage: one valid/ready slot carrying an
// instruction word and the byte address it was fetched from.
interface im_fetch_ctrl_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the instruction memory and
// registers each fetched word into a single valid/ready slot toward decode.
module im_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 1024,
    localparam int         ADDR_W   = $clog2(IM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset_n,

    output logic [ADDR_W-1:0]     im_addr,
    input  logic [31:0]           im_instr,

    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,

    im_fetch_ctrl_if.master       if_out,

    output logic                  fault,
    output logic [31:0]           fault_pc,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } state_e;

    // One past the last legal byte address; 33 bits so the bound cannot overflow.
    localparam logic [32:0] WIN_END = {1'b0, PC_RESET} + (33'(IM_WORDS) * 33'd4);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        slot_free;
    logic [31:0] pc_offset;

    function automatic logic in_window(input logic [31:0] addr);
        return (addr >= PC_RESET) && ({1'b0, addr} < WIN_END);
    endfunction

    assign pc_offset = pc_q - PC_RESET;
    assign im_addr   = ADDR_W'(pc_offset >> 2);
    assign slot_free = !if_valid_q || if_out.if_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    if ((redirect_pc[1:0] != 2'b00) || !in_window(redirect_pc)) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (slot_free && !stall) begin
                    if (!in_window(pc_q)) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                        if_valid_d = 1'b0;
                    end else begin
                        if_instr_d    = im_instr;
                        if_pc_d       = pc_q;
                        if_valid_d    = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end else if (slot_free) begin
                    // Stalled with a free slot: anything just consumed leaves the slot.
                    if_valid_d = 1'b0;
                end
            end

            FAULT: begin
                if (if_out.if_ready) begin
                    if_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BOOT;
            pc_q          <= PC_RESET;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= 32'd0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_out.if_valid = if_valid_q;
    assign if_out.if_instr = if_instr_q;
    assign if_out.if_pc    = if_pc_q;
    assign fault           = fault_q;
    assign fault_pc        = fault_pc_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: accepted instructions are checked against a
// scoreboard queue filled as fetches are provoked; control outputs checked directly.
module tb_im_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [9:0]  im_addr;
    logic [31:0] im_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    im_fetch_ctrl_if ifc ();

    im_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_out         (ifc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    // Instruction memory model: every word is distinct and encodes its own index.
    function automatic logic [31:0] im_word(input logic [9:0] a);
        return {6'h2A, a, ~a, 6'h15};
    endfunction

    assign im_instr = im_word(im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = im_word(10'((pc - 32'h3000) >> 2));
        sb.push_back(e);
    endtask

    // Drives one cycle of inputs at a falling edge; a slot transfer happening on
    // the coming rising edge is checked against the scoreboard before it occurs.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
        exp_t e;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ifc.if_ready   = rdy;
        #1;
        if (ifc.if_valid === 1'b1 && rdy) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow_pc", ifc.if_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_pc", ifc.if_pc, e.pc);
                checkOutput("sb_instr", ifc.if_instr, e.instr);
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        ifc.if_ready   = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_valid", 32'(ifc.if_valid), 32'd0);
        checkOutput("rst_pc", ifc.if_pc, 32'd0);
        checkOutput("rst_instr", ifc.if_instr, 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_fault_pc", fault_pc, 32'd0);
        checkOutput("rst_count", fetch_count, 32'd0);
        checkOutput("rst_im_addr", 32'(im_addr), 32'd0);

        // Boot and stream three words
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("boot_valid", 32'(ifc.if_valid), 32'd0);
        pushExpected(32'h3000);
        pushExpected(32'h3004);
        pushExpected(32'h3008);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("first_pc", ifc.if_pc, 32'h3000);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("stream_pc", ifc.if_pc, 32'h3008);
        checkOutput("stream_count", fetch_count, 32'd3);

        // Backpressure holds the slot and the PC
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("bp_pc", ifc.if_pc, 32'h3008);
            checkOutput("bp_instr", ifc.if_instr, im_word(10'd2));
            checkOutput("bp_im_addr", 32'(im_addr), 32'd3);
        end
        checkOutput("bp_count", fetch_count, 32'd3);

        // Stall with the slot consumed
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("stall_valid", 32'(ifc.if_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("stall_valid2", 32'(ifc.if_valid), 32'd0);
        checkOutput("stall_im_addr", 32'(im_addr), 32'd3);
        checkOutput("stall_count", fetch_count, 32'd3);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("resume_pc", ifc.if_pc, 32'h300C);
        checkOutput("resume_instr", ifc.if_instr, im_word(10'd3));
        checkOutput("resume_count", fetch_count, 32'd4);

        // Redirect flushes an unconsumed slot
        applyStimulus(1'b0, 1'b1, 32'h3100, 1'b0);
        checkOutput("flush_valid", 32'(ifc.if_valid), 32'd0);
        checkOutput("flush_im_addr", 32'(im_addr), 32'h40);
        checkOutput("flush_count", fetch_count, 32'd4);
        pushExpected(32'h3100);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("redir_pc", ifc.if_pc, 32'h3100);

        // Redirect wins over stall
        applyStimulus(1'b1, 1'b1, 32'h3200, 1'b1);
        checkOutput("redir_stall_valid", 32'(ifc.if_valid), 32'd0);
        checkOutput("redir_stall_im_addr", 32'(im_addr), 32'h80);
        pushExpected(32'h3200);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("redir_stall_count", fetch_count, 32'd6);

        // Misaligned redirect faults; later redirects are ignored
        applyStimulus(1'b0, 1'b1, 32'h3102, 1'b1);
        checkOutput("mis_fault", 32'(fault), 32'd1);
        checkOutput("mis_fault_pc", fault_pc, 32'h3102);
        checkOutput("mis_valid", 32'(ifc.if_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h3000, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("mis_hold_fault", 32'(fault), 32'd1);
        checkOutput("mis_hold_fault_pc", fault_pc, 32'h3102);
        checkOutput("mis_hold_valid", 32'(ifc.if_valid), 32'd0);
        checkOutput("mis_hold_count", fetch_count, 32'd6);
        checkOutput("mis_hold_im_addr", 32'(im_addr), 32'h81);

        // Last word of the window is fetched, the next one faults
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h3FFC, 1'b1);
        checkOutput("end_im_addr", 32'(im_addr), 32'h3FF);
        checkOutput("end_fault0", 32'(fault), 32'd0);
        pushExpected(32'h3FFC);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("end_pc", ifc.if_pc, 32'h3FFC);
        checkOutput("end_count", fetch_count, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("end_fault", 32'(fault), 32'd1);
        checkOutput("end_fault_pc", fault_pc, 32'h4000);
        checkOutput("end_valid", 32'(ifc.if_valid), 32'd0);
        checkOutput("end_count2", fetch_count, 32'd1);

        // Asynchronous reset in the middle of streaming
        doReset();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        pushExpected(32'h3000);
        pushExpected(32'h3004);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("pre_arst_count", fetch_count, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(ifc.if_valid), 32'd0);
        checkOutput("arst_fault", 32'(fault), 32'd0);
        checkOutput("arst_count", fetch_count, 32'd0);
        checkOutput("arst_im_addr", 32'(im_addr), 32'd0);
        checkOutput("arst_pc", ifc.if_pc, 32'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("arst_boot_valid", 32'(ifc.if_valid), 32'd0);
        pushExpected(32'h3000);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("arst_first_pc", ifc.if_pc, 32'h3000);
        checkOutput("arst_first_count", fetch_count, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("sb_drained", 32'(sb.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
